// File: rtl/doodle_pkg.sv
// Shared state encodings, screen geometry and the horizontal step helper
// for the doodle physics core.
package doodle_pkg;

    // One-hot game state; any other encoding is treated as illegal.
    typedef enum logic [3:0] {
        ST_I    = 4'b0001,
        ST_UP   = 4'b0010,
        ST_DOWN = 4'b0100,
        ST_DONE = 4'b1000
    } state_t;

    // Visible screen area in pixel coordinates.
    localparam logic [9:0] H_LEFT  = 10'd144;
    localparam logic [9:0] H_RIGHT = 10'd773;
    localparam logic [9:0] V_TOP   = 10'd35;
    localparam logic [9:0] V_BOT   = 10'd515;
    localparam logic [9:0] H_MID   = 10'd459;

    // One horizontal step: Left or Right alone moves one pixel, both or
    // neither hold; leaving either side re-enters at the opposite edge.
    function automatic logic [9:0] step_x(input logic [9:0] x,
                                          input logic       left,
                                          input logic       right);
        logic [9:0] nx;
        nx = x;
        if (left && !right)
            nx = x - 10'd1;
        else if (right && !left)
            nx = x + 10'd1;
        if (nx < H_LEFT)
            nx = H_RIGHT;
        else if (nx > H_RIGHT)
            nx = H_LEFT;
        return nx;
    endfunction

endpackage

// File: rtl/doodle_physics_core_if.sv
// Control, platform and status signals of the doodle physics core.
// master drives the controls and platform list; slave is the core.
interface doodle_physics_core_if #(
    parameter int NUM_PLAT = 4,
    parameter int SCORE_W  = 16
);
    logic                     Start;
    logic                     Ack;
    logic                     Tick;
    logic                     Left;
    logic                     Right;
    logic [NUM_PLAT*10-1:0]   plat_x;
    logic [NUM_PLAT*10-1:0]   plat_y;
    logic [9:0]               doodle_x;
    logic [9:0]               doodle_y;
    logic [9:0]               scroll_count;
    logic [SCORE_W-1:0]       score;
    logic                     q_I;
    logic                     q_Up;
    logic                     q_Down;
    logic                     q_Done;
    logic [3:0]               land_idx;

    modport master (
        output Start, Ack, Tick, Left, Right, plat_x, plat_y,
        input  doodle_x, doodle_y, scroll_count, score,
               q_I, q_Up, q_Down, q_Done, land_idx
    );

    modport slave (
        input  Start, Ack, Tick, Left, Right, plat_x, plat_y,
        output doodle_x, doodle_y, scroll_count, score,
               q_I, q_Up, q_Down, q_Done, land_idx
    );
endinterface

// File: rtl/doodle_land_detect.sv
// Combinational landing test: the doodle's foot point (centre + radius on
// both axes) is compared against every platform rectangle, and the lowest
// matching platform index wins.
module doodle_land_detect #(
    parameter int NUM_PLAT      = 4,
    parameter int DOODLE_RADIUS = 10,
    parameter int PLAT_W        = 64,
    parameter int PLAT_H        = 16
) (
    input  logic [9:0]            pos_x,
    input  logic [9:0]            pos_y,
    input  logic [NUM_PLAT*10-1:0] plat_x,
    input  logic [NUM_PLAT*10-1:0] plat_y,
    output logic                  hit,
    output logic [3:0]            idx
);
    // 11-bit math so platform far edges near 1023 do not wrap.
    logic [10:0]         foot_x;
    logic [10:0]         foot_y;
    logic [NUM_PLAT-1:0] match;

    assign foot_x = {1'b0, pos_x} + 11'(DOODLE_RADIUS);
    assign foot_y = {1'b0, pos_y} + 11'(DOODLE_RADIUS);

    for (genvar k = 0; k < NUM_PLAT; k++) begin : g_cmp
        logic [10:0] px;
        logic [10:0] py;
        assign px = {1'b0, plat_x[10*k +: 10]};
        assign py = {1'b0, plat_y[10*k +: 10]};
        assign match[k] = (foot_x >= px) && (foot_x <= px + 11'(PLAT_W - 1)) &&
                          (foot_y >= py) && (foot_y <= py + 11'(PLAT_H - 1));
    end

    // Priority encoder: scan high to low so the lowest match is written last.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int k = NUM_PLAT - 1; k >= 0; k--) begin
            if (match[k]) begin
                hit = 1'b1;
                idx = 4'(k);
            end
        end
    end
endmodule

// File: rtl/doodle_physics_core.sv
// Doodle jump physics: a rise of JUMP_HEIGHT ticks, a fall that either lands
// on a platform (starting a new rise) or drops out of the screen. Above the
// scroll line the doodle is held and the world scrolls instead, which also
// earns score. All outputs come straight from registers.
module doodle_physics_core
    import doodle_pkg::*;
#(
    parameter int NUM_PLAT      = 4,
    parameter int JUMP_HEIGHT   = 120,
    parameter int DOODLE_RADIUS = 10,
    parameter int PLAT_W        = 64,
    parameter int PLAT_H        = 16,
    parameter int SCROLL_LINE   = 275,
    parameter int SCORE_W       = 16
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    doodle_physics_core_if.slave bus
);
    localparam int         CNT_W   = $clog2(JUMP_HEIGHT + 1);
    localparam logic [9:0] Y_START = 10'(int'(V_BOT) - DOODLE_RADIUS - 1);

    state_t               state_q, state_d;
    logic [9:0]           x_q, x_d;
    logic [9:0]           y_q, y_d;
    logic [9:0]           scroll_q, scroll_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [3:0]           land_q, land_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 hit;
    logic [3:0]           hit_idx;
    logic [10:0]          foot_y;

    // Landing is judged on the current (pre-step) position.
    doodle_land_detect #(
        .NUM_PLAT      (NUM_PLAT),
        .DOODLE_RADIUS (DOODLE_RADIUS),
        .PLAT_W        (PLAT_W),
        .PLAT_H        (PLAT_H)
    ) u_land (
        .pos_x  (x_q),
        .pos_y  (y_q),
        .plat_x (bus.plat_x),
        .plat_y (bus.plat_y),
        .hit    (hit),
        .idx    (hit_idx)
    );

    assign foot_y = {1'b0, y_q} + 11'(DOODLE_RADIUS);

    // State and datapath registers; reset may strike at any point in a jump.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_I;
            x_q      <= H_MID;
            y_q      <= Y_START;
            scroll_q <= '0;
            score_q  <= '0;
            land_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            scroll_q <= scroll_d;
            score_q  <= score_d;
            land_q   <= land_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next state and motion; everything but Start/Ack waits for Tick.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        scroll_d = scroll_q;
        score_d  = score_q;
        land_d   = land_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_I: begin
                if (bus.Start) begin
                    state_d  = ST_UP;
                    x_d      = H_MID;
                    y_d      = Y_START;
                    scroll_d = '0;
                    score_d  = '0;
                    cnt_d    = '0;
                end
            end
            ST_UP: begin
                if (bus.Tick) begin
                    x_d = step_x(x_q, bus.Left, bus.Right);
                    if (y_q > 10'(SCROLL_LINE)) begin
                        y_d = y_q - 10'd1;
                    end else begin
                        scroll_d = scroll_q + 10'd1;
                        if (score_q != '1)
                            score_d = score_q + SCORE_W'(1);
                    end
                    if (cnt_q == CNT_W'(JUMP_HEIGHT - 1)) begin
                        state_d = ST_DOWN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DOWN: begin
                if (bus.Tick) begin
                    x_d = step_x(x_q, bus.Left, bus.Right);
                    y_d = y_q + 10'd1;
                    // A landing beats falling out on the same tick.
                    if (hit) begin
                        state_d = ST_UP;
                        land_d  = hit_idx;
                    end else if (foot_y > {1'b0, V_BOT}) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (bus.Ack)
                    state_d = ST_I;
            end
            default: state_d = ST_I;
        endcase
    end

    assign bus.doodle_x     = x_q;
    assign bus.doodle_y     = y_q;
    assign bus.scroll_count = scroll_q;
    assign bus.score        = score_q;
    assign bus.land_idx     = land_q;
    assign bus.q_I          = state_q[0];
    assign bus.q_Up         = state_q[1];
    assign bus.q_Down       = state_q[2];
    assign bus.q_Done       = state_q[3];
endmodule

// File: tb/tb_doodle_physics_core.sv
// Randomised bench for doodle_physics_core with a behavioural game model.
module tb_doodle_physics_core;
    localparam int NP = 4, JH = 120, R = 10, PW = 64, PH = 16, SL = 275, SW = 16;

    logic Clk = 1'b0;
    logic Reset_n;
    always #5 Clk = ~Clk;

    doodle_physics_core_if #(.NUM_PLAT(NP), .SCORE_W(SW)) bus();

    doodle_physics_core #(
        .NUM_PLAT(NP), .JUMP_HEIGHT(JH), .DOODLE_RADIUS(R), .PLAT_W(PW),
        .PLAT_H(PH), .SCROLL_LINE(SL), .SCORE_W(SW)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    // Model: mode 0 idle, 1 rising, 2 falling, 3 game over.
    int m_mode, m_x, m_y, m_scroll, m_score, m_land, m_cnt;
    int px [NP];
    int py [NP];
    int n_chk = 0, n_fail = 0;
    bit chk_en = 0;
    bit autoland = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_x = 459; m_y = 504;
        m_scroll = 0; m_score = 0; m_land = 0; m_cnt = 0;
    endtask

    function automatic int hmove(input int x, input bit l, input bit r);
        int nx;
        nx = x + (r ? 1 : 0) - (l ? 1 : 0);
        if (nx < 144) nx = 773;
        else if (nx > 773) nx = 144;
        return nx;
    endfunction

    function automatic bit lands(input int k, input int x, input int y);
        return (x + R >= px[k]) && (x + R <= px[k] + PW - 1) &&
               (y + R >= py[k]) && (y + R <= py[k] + PH - 1);
    endfunction

    task automatic model_step();
        int hitk;
        int fy;
        if (!Reset_n) return;
        case (m_mode)
            0: if (bus.Start) begin
                m_mode = 1; m_x = 459; m_y = 504;
                m_score = 0; m_scroll = 0; m_cnt = 0;
            end
            1: if (bus.Tick) begin
                m_x = hmove(m_x, bus.Left, bus.Right);
                if (m_y > SL) m_y--;
                else begin
                    m_scroll = (m_scroll + 1) % 1024;
                    if (m_score < (1 << SW) - 1) m_score++;
                end
                m_cnt++;
                if (m_cnt == JH) begin m_mode = 2; m_cnt = 0; end
            end
            2: if (bus.Tick) begin
                hitk = -1;
                for (int k = NP - 1; k >= 0; k--)
                    if (lands(k, m_x, m_y)) hitk = k;
                fy = m_y + R;
                m_x = hmove(m_x, bus.Left, bus.Right);
                m_y++;
                if (hitk >= 0) begin m_mode = 1; m_land = hitk; end
                else if (fy > 515) m_mode = 3;
            end
            default: if (bus.Ack) m_mode = 0;
        endcase
    endtask

    task automatic clear_plats();
        for (int k = 0; k < NP; k++) begin px[k] = 0; py[k] = 0; end
    endtask

    // One clock: drive inputs, step the model on the edge, return 1 after it.
    task automatic cyc(input bit t, input bit l, input bit r, input bit s, input bit a);
        if (autoland && m_mode == 2) begin
            px[0] = m_x + R - 30;
            py[0] = m_y + R - 3;
        end
        bus.Tick = t; bus.Left = l; bus.Right = r; bus.Start = s; bus.Ack = a;
        for (int k = 0; k < NP; k++) begin
            bus.plat_x[10*k +: 10] = 10'(px[k]);
            bus.plat_y[10*k +: 10] = 10'(py[k]);
        end
        @(posedge Clk);
        model_step();
        #1;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) cyc(0, 1'($urandom), 1'($urandom), 0, 0);
            cyc(1, 1'($urandom), 1'($urandom), 0, 0);
        end
    endtask

    // Every cycle out of reset the DUT must match the model.
    always @(negedge Clk) begin
        if (chk_en && Reset_n) begin
            check("doodle_x", bus.doodle_x, m_x);
            check("doodle_y", bus.doodle_y, m_y);
            check("scroll_count", bus.scroll_count, m_scroll);
            check("score", bus.score, m_score);
            check("land_idx", bus.land_idx, m_land);
            check("q_I", bus.q_I, m_mode == 0);
            check("q_Up", bus.q_Up, m_mode == 1);
            check("q_Down", bus.q_Down, m_mode == 2);
            check("q_Done", bus.q_Done, m_mode == 3);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, sc, dens;
        Reset_n = 1'b0;
        bus.Start = 0; bus.Ack = 0; bus.Tick = 0; bus.Left = 0; bus.Right = 0;
        bus.plat_x = '0; bus.plat_y = '0;
        clear_plats();
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        check("rst_x", bus.doodle_x, 459);
        check("rst_y", bus.doodle_y, 504);
        check("rst_qI", bus.q_I, 1);
        check("rst_score", bus.score, 0);
        check("rst_land", bus.land_idx, 0);
        Reset_n = 1'b1;
        chk_en = 1;

        // Tick while idle does nothing.
        cyc(1, 1, 0, 0, 0);
        check("idle_tick_qI", bus.q_I, 1);
        check("idle_tick_x", bus.doodle_x, 459);

        cyc(0, 0, 0, 1, 0);
        check("start_qUp", bus.q_Up, 1);
        check("start_y", bus.doodle_y, 504);

        run_ticks(JH);
        check("jump_qDown", bus.q_Down, 1);
        check("jump_y", bus.doodle_y, 384);

        px[1] = m_x + R - 30; py[1] = m_y + R - 3;
        cyc(1, 0, 0, 0, 0);
        check("land1_qUp", bus.q_Up, 1);
        check("land1_idx", bus.land_idx, 1);
        check("land1_y", bus.doodle_y, 385);
        clear_plats();

        run_ticks(JH);
        check("scroll_y", bus.doodle_y, 275);
        check("scroll_cnt", bus.scroll_count, 10);
        check("scroll_score", bus.score, 10);

        // Platforms 0 and 2 overlap at their edges; 1 and 3 miss by one pixel.
        px[0] = m_x + R;      py[0] = m_y + R;
        px[1] = m_x + R + 1;  py[1] = m_y + R;
        px[2] = m_x + R - 63; py[2] = m_y + R - 15;
        px[3] = m_x + R;      py[3] = m_y + R - 16;
        cyc(1, 0, 0, 0, 0);
        check("prio_qUp", bus.q_Up, 1);
        check("prio_idx", bus.land_idx, 0);
        clear_plats();

        run_ticks(JH);
        g = 0;
        while (m_mode == 2 && g < 400) begin
            cyc(1, 1'($urandom), 1'($urandom), 0, 0);
            g++;
        end
        check("fall_ticks", g, 232);
        check("fall_qDone", bus.q_Done, 1);
        check("fall_score", bus.score, 129);
        sc = m_score;
        repeat (3) cyc(1, 1, 0, 1, 0);
        check("done_hold", bus.q_Done, 1);
        check("done_score", bus.score, sc);
        cyc(0, 0, 0, 0, 1);
        check("ack_qI", bus.q_I, 1);
        repeat (3) cyc(1, 0, 1, 0, 0);
        check("idle_score", bus.score, sc);

        // Horizontal wrap with auto landing keeping the game alive.
        cyc(0, 0, 0, 1, 0);
        check("restart_score", bus.score, 0);
        autoland = 1;
        g = 0;
        while (m_x != 144 && g < 1000) begin cyc(1, 1, 0, 0, 0); g++; end
        check("wrap_reach", bus.doodle_x, 144);
        cyc(1, 1, 0, 0, 0);
        check("wrap_left", bus.doodle_x, 773);
        cyc(1, 1, 1, 0, 0);
        check("both_hold", bus.doodle_x, 773);
        cyc(1, 0, 1, 0, 0);
        check("wrap_right", bus.doodle_x, 144);
        cyc(0, 1, 0, 0, 0);
        check("no_tick_hold", bus.doodle_x, 144);

        // Asynchronous reset in the middle of a rise.
        g = 0;
        while (m_mode != 1 && g < 300) begin cyc(1, 0, 0, 0, 0); g++; end
        repeat (20) cyc(1, 0, 1, 0, 0);
        #3;
        Reset_n = 1'b0;
        model_reset();
        #1;
        check("arst_qI", bus.q_I, 1);
        check("arst_x", bus.doodle_x, 459);
        check("arst_y", bus.doodle_y, 504);
        check("arst_score", bus.score, 0);
        check("arst_scroll", bus.scroll_count, 0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        autoland = 0;
        clear_plats();
        cyc(1, 1, 0, 0, 0);
        check("post_rst_qI", bus.q_I, 1);

        // Random play with varying platform density near the doodle.
        dens = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) dens = int'($urandom_range(0, 3));
            for (int k = 0; k < NP; k++) begin
                if (int'($urandom_range(0, 3)) < dens) begin
                    px[k] = m_x + R - int'($urandom_range(0, 70));
                    py[k] = m_y + R - int'($urandom_range(0, 20));
                end else begin
                    px[k] = 0; py[k] = 0;
                end
            end
            cyc($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
        end

        @(negedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/doodle_physics_core.md
DOODLE_PHYSICS_CORE -- requirements
Module: doodle_physics_core

Interface
REQ-001 SHALL have parameter NUM_PLAT, default 4, number of platforms checked for landing (1..16).
REQ-002 SHALL have parameter JUMP_HEIGHT, default 120, rise in pixels per jump.
REQ-003 SHALL have parameter DOODLE_RADIUS, default 10, centre-to-edge distance in pixels.
REQ-004 SHALL have parameter PLAT_W, default 64, and PLAT_H, default 16, platform size in pixels.
REQ-005 SHALL have parameter SCROLL_LINE, default 275, the screen row above which the doodle is held and the world scrolls.
REQ-006 SHALL have parameter SCORE_W, default 16, score width.
REQ-007 Clk  in  1  system clock.
REQ-008 Reset_n  in  1  one clock; reset is asynchronous and active-low.
REQ-009 Start, Ack  in  1 each  leave I; leave DONE.
REQ-010 Tick  in  1  one-cycle physics step enable (once per frame).
REQ-011 Left, Right  in  1 each  horizontal move requests.
REQ-012 plat_x, plat_y  in  NUM_PLAT*10 each  flattened platform top-left screen coordinates; platform k at bits [10k+9:10k].
REQ-013 doodle_x, doodle_y  out  10 each  doodle centre in screen coordinates.
REQ-014 scroll_count  out  10  total pixels scrolled, wraps modulo 1024.
REQ-015 score  out  SCORE_W  saturating score.
REQ-016 q_I, q_Up, q_Down, q_Done  out  1 each  one-hot state.
REQ-017 land_idx  out  4  index of the last platform landed on.

Function
REQ-018 States I, UP, DOWN, DONE, one-hot; an illegal encoding SHALL return to I on the next clock.
REQ-019 All motion and state changes except Start/Ack transitions SHALL occur only on cycles with Tick=1.
REQ-020 I: on Start, go to UP.
  - Load doodle_x=459, doodle_y=515-DOODLE_RADIUS-1.
  - Clear score, scroll_count and the jump counter.
REQ-021 UP, on each Tick:
  - Jump counter +1.
  - If doodle_y > SCROLL_LINE, doodle_y −1; otherwise doodle_y holds, scroll_count +1 and score +1, saturating at all-ones.
REQ-022 UP: when the jump counter reaches JUMP_HEIGHT (after exactly JUMP_HEIGHT Ticks in UP), go to DOWN and clear the counter.
REQ-023 DOWN, on each Tick: doodle_y +1.
  - Landing on platform k requires all of: doodle_x+DOODLE_RADIUS in [plat_x_k, plat_x_k+PLAT_W-1]; doodle_y+DOODLE_RADIUS in [plat_y_k, plat_y_k+PLAT_H-1]; both evaluated on the pre-increment position.
  - On landing, go to UP and set land_idx=k.
REQ-024 If several platforms match, the lowest index SHALL win.
REQ-025 DOWN: if there is no landing and doodle_y+DOODLE_RADIUS > 515, go to DONE. A landing SHALL take priority over fall-out on the same Tick.
REQ-026 DONE: doodle position and score SHALL freeze; Ack SHALL go to I. Start SHALL be ignored outside I.
REQ-027 Horizontal motion, UP and DOWN only, per Tick:
  - Left alone: doodle_x −1. Right alone: doodle_x +1. Both or neither: hold.
  - doodle_x < 144 SHALL wrap to 773; doodle_x > 773 SHALL wrap to 144.
REQ-028 Outputs SHALL be registered; a Tick effect SHALL be visible one clock after the Tick cycle.

Reset
REQ-029 Reset_n=0 SHALL, asynchronously and at any point mid-jump, set:
  - state=I, doodle_x=459, doodle_y=504.
  - scroll_count=0, score=0, land_idx=0, jump counter=0.
REQ-030 The first Tick after reset release SHALL have no effect unless state has already left I.

Structure
REQ-031 Package doodle_pkg SHALL hold the state encodings and the screen constants: H_LEFT=144, H_RIGHT=773, V_TOP=35, V_BOT=515, H_MID=459.
REQ-032 Sub-module doodle_land_detect SHALL hold the combinational NUM_PLAT comparator array with a priority encoder, outputting hit and index.

Verification
REQ-033 Reset, Start, JUMP_HEIGHT Ticks with no platforms in range -> q_Down=1 after exactly 120 Ticks; doodle_y=384.
REQ-034 Keep jumping to SCROLL_LINE -> doodle_y holds at 275 while scroll_count and score advance 1 per Tick.
REQ-035 DOWN with platforms 0 and 2 both overlapping the doodle -> q_Up=1 and land_idx=0 one clock after the Tick.
REQ-036 DOWN with no platforms until doodle_y+10 > 515 -> q_Done=1; Ack -> q_I=1; further Ticks do not change score.
REQ-037 Left held at doodle_x=144 -> next Tick doodle_x=773; Left and Right together -> doodle_x unchanged.
REQ-038 Reset_n pulsed low mid-UP, with no clock edge -> outputs at reset values immediately; score=0.
